// File: rtl/psg_mixer.sv
// psg_mixer: once per sample strobe, mixes three PSG channels plus the beeper,
// EAR and MIC bits into saturated 12-bit left/right samples. A one-pole
// low-pass filter then smooths them before they go to the I2S/HDMI packing.
//
// Sequence per sample (one state per clock):
//   IDLE -> MIXL -> MIXR -> FILTL -> FILTR -> OUT -> IDLE
// Each mix state and each filter state handles one channel. They share one
// accumulator and one filter datapath. When OUT is left, a publish flag is
// armed. On the following edge, with the FSM already back in IDLE and able
// to accept the next strobe, laudio/raudio load and valid pulses.
//
// Handshake: valid is a one-clock pulse with no ready. The consumer must take
// laudio/raudio on that cycle; they hold until the next pulse. A ce that
// arrives outside IDLE is dropped and latches the sticky overrun flag.
module psg_mixer #(
    parameter int          FILTER_SHIFT = 3,
    parameter logic [11:0] SPK_LEVEL    = 12'd1536,
    parameter logic [11:0] EAR_LEVEL    = 12'd512,
    parameter logic [11:0] MIC_LEVEL    = 12'd128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        speaker,
    input  logic        ear,
    input  logic        mic,
    input  logic [7:0]  chA,
    input  logic [7:0]  chB,
    input  logic [7:0]  chC,
    input  logic [1:0]  stereo,
    output logic [11:0] laudio,
    output logic [11:0] raudio,
    output logic        valid,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MIXL  = 3'd1,
        S_MIXR  = 3'd2,
        S_FILTL = 3'd3,
        S_FILTR = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        spk_q, spk_d, ear_q, ear_d, mic_q, mic_d;
    logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]  st_q, st_d;
    logic [11:0] xl_q, xl_d, xr_q, xr_d;
    logic [11:0] yl_q, yl_d, yr_q, yr_d;
    logic        pub_q, pub_d;
    logic [11:0] laudio_q, laudio_d, raudio_q, raudio_d;
    logic        valid_q, valid_d, overrun_q, overrun_d;

    logic               is_left;
    logic [9:0]         psg_term;
    logic [13:0]        mix_sum;
    logic [11:0]        mix_sat;
    logic [11:0]        x_sel, y_sel, y_new;
    logic signed [12:0] diff, step;

    // Shared mixing and filter datapath; the current state picks the channel.
    always_comb begin
        is_left = (state_q == S_MIXL) || (state_q == S_FILTL);

        psg_term = '0;
        if (st_q[1])
            psg_term = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};
        else if (!st_q[0])
            psg_term = is_left ? ({1'b0, a_q, 1'b0} + {2'b00, b_q})
                               : ({1'b0, c_q, 1'b0} + {2'b00, b_q});
        else
            psg_term = is_left ? ({1'b0, a_q, 1'b0} + {2'b00, c_q})
                               : ({1'b0, b_q, 1'b0} + {2'b00, c_q});

        // Worst case is 765 + 3*4095, so 14 bits cannot wrap.
        mix_sum = {4'b0000, psg_term}
                + (spk_q ? {2'b00, SPK_LEVEL} : 14'd0)
                + (ear_q ? {2'b00, EAR_LEVEL} : 14'd0)
                + (mic_q ? {2'b00, MIC_LEVEL} : 14'd0);
        mix_sat = (mix_sum > 14'd4095) ? 12'hFFF : mix_sum[11:0];

        // y += (x - y) >>> k. Floor rounding keeps y within [0, 4095].
        x_sel = is_left ? xl_q : xr_q;
        y_sel = is_left ? yl_q : yr_q;
        diff  = $signed({1'b0, x_sel}) - $signed({1'b0, y_sel});
        step  = diff >>> FILTER_SHIFT;
        y_new = 12'($unsigned({1'b0, y_sel}) + $unsigned(step));
    end

    // Next-state logic for the FSM, sample capture, filter state and outputs.
    always_comb begin
        state_d   = state_q;
        spk_d     = spk_q;
        ear_d     = ear_q;
        mic_d     = mic_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        st_d      = st_q;
        xl_d      = xl_q;
        xr_d      = xr_q;
        yl_d      = yl_q;
        yr_d      = yr_q;
        pub_d     = 1'b0;
        laudio_d  = laudio_q;
        raudio_d  = raudio_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (ce) begin
                    spk_d   = speaker;
                    ear_d   = ear;
                    mic_d   = mic;
                    a_d     = chA;
                    b_d     = chB;
                    c_d     = chC;
                    st_d    = stereo;
                    state_d = S_MIXL;
                end
            end
            S_MIXL:  begin xl_d = mix_sat; state_d = S_MIXR;  end
            S_MIXR:  begin xr_d = mix_sat; state_d = S_FILTL; end
            S_FILTL: begin yl_d = y_new;   state_d = S_FILTR; end
            S_FILTR: begin yr_d = y_new;   state_d = S_OUT;   end
            S_OUT:   begin pub_d = 1'b1;   state_d = S_IDLE;  end
            default: state_d = S_IDLE;
        endcase

        if (ce && (state_q != S_IDLE))
            overrun_d = 1'b1;

        if (pub_q) begin
            laudio_d = yl_q;
            raudio_d = yr_q;
            valid_d  = 1'b1;
        end
    end

    // State registers; reset drops any sample in flight and its publish flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            spk_q     <= 1'b0;
            ear_q     <= 1'b0;
            mic_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            st_q      <= '0;
            xl_q      <= '0;
            xr_q      <= '0;
            yl_q      <= '0;
            yr_q      <= '0;
            pub_q     <= 1'b0;
            laudio_q  <= '0;
            raudio_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            spk_q     <= spk_d;
            ear_q     <= ear_d;
            mic_q     <= mic_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            st_q      <= st_d;
            xl_q      <= xl_d;
            xr_q      <= xr_d;
            yl_q      <= yl_d;
            yr_q      <= yr_d;
            pub_q     <= pub_d;
            laudio_q  <= laudio_d;
            raudio_q  <= raudio_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign laudio    = laudio_q;
    assign raudio    = raudio_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_psg_mixer.sv
// Bench for psg_mixer. Three instances share the same stimulus:
//   u0 - FILTER_SHIFT=0, default levels (filter bypassed)
//   u3 - FILTER_SHIFT=3, default levels
//   us - FILTER_SHIFT=0, SPK_LEVEL=EAR_LEVEL=4095 (saturation)
// A behavioural model computes each expected sample from the mixing rules.
// Expected samples go into a queue in strobe order and are popped on valid.
module tb_psg_mixer;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b0;
    logic       ce = 1'b0, speaker = 1'b0, ear = 1'b0, mic = 1'b0;
    logic [7:0] chA = '0, chB = '0, chC = '0;
    logic [1:0] stereo = '0;

    logic [11:0] l0, r0, l3, r3, ls, rs;
    logic        v0, v3, vs, o0, o3, os;
    logic [2:0]  s0, s3, ss;

    psg_mixer #(.FILTER_SHIFT(0)) u0 (
        .clock(clock), .reset(reset), .ce(ce), .speaker(speaker), .ear(ear), .mic(mic),
        .chA(chA), .chB(chB), .chC(chC), .stereo(stereo),
        .laudio(l0), .raudio(r0), .valid(v0), .overrun(o0), .dbg_state(s0));
    psg_mixer #(.FILTER_SHIFT(3)) u3 (
        .clock(clock), .reset(reset), .ce(ce), .speaker(speaker), .ear(ear), .mic(mic),
        .chA(chA), .chB(chB), .chC(chC), .stereo(stereo),
        .laudio(l3), .raudio(r3), .valid(v3), .overrun(o3), .dbg_state(s3));
    psg_mixer #(.FILTER_SHIFT(0), .SPK_LEVEL(12'd4095), .EAR_LEVEL(12'd4095)) us (
        .clock(clock), .reset(reset), .ce(ce), .speaker(speaker), .ear(ear), .mic(mic),
        .chA(chA), .chB(chB), .chC(chC), .stereo(stereo),
        .laudio(ls), .raudio(rs), .valid(vs), .overrun(os), .dbg_state(ss));

    int n_vec = 0;
    int n_err = 0;
    logic [71:0] exp_q[$];
    int y0l, y0r, y3l, y3r, ysl, ysr;

    // ---------------- reference model ----------------
    function automatic int psg(bit left, int a, int b, int c, logic [1:0] st);
        if (st[1]) return a + b + c;
        if (st == 2'b00) return left ? 2 * a + b : 2 * c + b;
        return left ? 2 * a + c : 2 * b + c;
    endfunction

    function automatic int mixv(int p, bit s, bit e, bit m, int sl, int el, int ml);
        int t;
        t = p + (s ? sl : 0) + (e ? el : 0) + (m ? ml : 0);
        return (t > 4095) ? 4095 : t;
    endfunction

    function automatic int filt(int y, int x, int k);
        int d, den, q;
        d   = x - y;
        den = 1 << k;
        if (d >= 0) q = d / den;
        else        q = -((-d + den - 1) / den);
        return y + q;
    endfunction

    task automatic model_push();
        int pl, pr;
        pl  = psg(1'b1, int'(chA), int'(chB), int'(chC), stereo);
        pr  = psg(1'b0, int'(chA), int'(chB), int'(chC), stereo);
        y0l = filt(y0l, mixv(pl, speaker, ear, mic, 1536, 512, 128), 0);
        y0r = filt(y0r, mixv(pr, speaker, ear, mic, 1536, 512, 128), 0);
        y3l = filt(y3l, mixv(pl, speaker, ear, mic, 1536, 512, 128), 3);
        y3r = filt(y3r, mixv(pr, speaker, ear, mic, 1536, 512, 128), 3);
        ysl = filt(ysl, mixv(pl, speaker, ear, mic, 4095, 4095, 128), 0);
        ysr = filt(ysr, mixv(pr, speaker, ear, mic, 4095, 4095, 128), 0);
        exp_q.push_back({12'(y0l), 12'(y0r), 12'(y3l), 12'(y3r), 12'(ysl), 12'(ysr)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ce    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        y0l = 0; y0r = 0; y3l = 0; y3r = 0; ysl = 0; ysr = 0;
        exp_q.delete();
    endtask

    task automatic set_in(int a, int b, int c, int st, bit s, bit e, bit m);
        chA = 8'(a); chB = 8'(b); chC = 8'(c); stereo = 2'(st);
        speaker = s; ear = e; mic = m;
    endtask

    // One strobe; the inputs are scrambled after ce to prove they were captured.
    // Checks the latency, all six outputs, the single-cycle valid and the hold.
    task automatic run_sample(string tag);
        logic [71:0] e;
        int cyc;
        model_push();
        ce = 1'b1;
        tick();
        ce = 1'b0;
        set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
        cyc = 0;
        while (v0 !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (cyc != 6) begin
            n_err++;
            $display("FAIL %s latency: got %0d clocks, expected 6", tag, cyc);
        end
        n_vec++;
        if ({v3, vs} !== 2'b11) begin
            n_err++;
            $display("FAIL %s valid_all: got v3=%b vs=%b, expected 1 1", tag, v3, vs);
        end
        n_vec++;
        if ({l0, r0, l3, r3, ls, rs} !== e) begin
            n_err++;
            $display("FAIL %s samples: got u0=%0d/%0d u3=%0d/%0d us=%0d/%0d, expected %0d/%0d %0d/%0d %0d/%0d",
                     tag, l0, r0, l3, r3, ls, rs, e[71:60], e[59:48], e[47:36], e[35:24], e[23:12], e[11:0]);
        end
        tick();
        n_vec++;
        if (v0 !== 1'b0 || {l0, r0, l3, r3, ls, rs} !== e) begin
            n_err++;
            $display("FAIL %s pulse_hold: got valid=%b l0=%0d r0=%0d, expected valid=0 l0=%0d r0=%0d",
                     tag, v0, l0, r0, e[71:60], e[59:48]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({l0, r0, l3, r3, ls, rs} !== '0 || {v0, v3, vs, o0, o3, os} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got l0=%0d r0=%0d l3=%0d valid=%b%b%b overrun=%b%b%b, expected all 0",
                     l0, r0, l3, v0, v3, vs, o0, o3, os);
        end
        do_reset();
    endtask

    task automatic test_mono_full();
        set_in(255, 255, 255, 2, 0, 0, 0);
        run_sample("mono_full");
        n_vec++;
        if (l0 !== 12'd765 || r0 !== 12'd765) begin
            n_err++;
            $display("FAIL mono_765: got %0d/%0d, expected 765/765", l0, r0);
        end
    endtask

    task automatic test_stereo_maps();
        set_in(100, 10, 0, 0, 1, 0, 0);
        run_sample("abc");
        n_vec++;
        if (l0 !== 12'd1746 || r0 !== 12'd1546) begin
            n_err++;
            $display("FAIL abc_const: got %0d/%0d, expected 1746/1546", l0, r0);
        end
        set_in(100, 10, 0, 1, 1, 0, 0);
        run_sample("acb");
        n_vec++;
        if (r0 !== 12'd1556) begin
            n_err++;
            $display("FAIL acb_const: got right %0d, expected 1556", r0);
        end
    endtask

    task automatic test_saturate();
        set_in(255, 255, 255, 2, 1, 1, 1);
        run_sample("saturate");
        n_vec++;
        if (ls !== 12'd4095 || rs !== 12'd4095) begin
            n_err++;
            $display("FAIL saturate: got %0d/%0d, expected 4095/4095", ls, rs);
        end
    endtask

    task automatic test_filter_converge();
        int first3[3] = '{100, 187, 263};
        logic [11:0] prev;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_in(96, 96, 96, 2, 0, 1, 0);   // x = 288 + 512 = 800
            run_sample("filt_up");
            if (i < 3) begin
                n_vec++;
                if (int'(l3) != first3[i]) begin
                    n_err++;
                    $display("FAIL filt_step%0d: got %0d, expected %0d", i, l3, first3[i]);
                end
            end
        end
        n_vec++;
        if (l3 < 12'd793 || l3 > 12'd800 || r3 !== l3) begin
            n_err++;
            $display("FAIL filt_settle: got %0d/%0d, expected 793..800 both", l3, r3);
        end
        prev = l3;
        for (int i = 0; i < 60; i++) begin
            set_in(0, 0, 0, 2, 0, 0, 0);
            run_sample("filt_down");
            n_vec++;
            if (l3 > prev) begin
                n_err++;
                $display("FAIL filt_monotone: got %0d after %0d, expected no increase", l3, prev);
            end
            prev = l3;
        end
        n_vec++;
        if (l3 !== 12'd0 || r3 !== 12'd0) begin
            n_err++;
            $display("FAIL filt_floor: got %0d/%0d, expected 0/0", l3, r3);
        end
    endtask

    task automatic test_overrun();
        int pulses;
        logic [71:0] e;
        do_reset();
        set_in(50, 60, 70, 0, 0, 1, 1);
        model_push();
        e = exp_q.pop_front();
        ce = 1'b1; tick(); ce = 1'b0;
        tick(); tick();
        ce = 1'b1; tick(); ce = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (v0 === 1'b1) begin
                pulses++;
                n_vec++;
                if ({l0, r0, l3, r3, ls, rs} !== e) begin
                    n_err++;
                    $display("FAIL overrun_sample: got l0=%0d r0=%0d l3=%0d, expected %0d %0d %0d",
                             l0, r0, l3, e[71:60], e[59:48], e[47:36]);
                end
            end
        end
        n_vec++;
        if (pulses != 1 || {o0, o3, os} !== 3'b111) begin
            n_err++;
            $display("FAIL overrun_flag: got pulses=%0d overrun=%b%b%b, expected 1 and 111", pulses, o0, o3, os);
        end
        set_in(1, 2, 3, 2, 0, 0, 0);
        run_sample("after_overrun");
        n_vec++;
        if (o0 !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b, expected 1", o0);
        end
        do_reset();
        n_vec++;
        if ({o0, o3, os} !== 3'b000) begin
            n_err++;
            $display("FAIL overrun_clear: got %b%b%b, expected 000", o0, o3, os);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] e;
        do_reset();
        for (int k = 0; k <= 6 * 20; k++) begin
            if (k % 6 == 0 && k < 6 * 20) begin
                set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
                model_push();
                ce = 1'b1;
            end else begin
                ce = 1'b0;
            end
            tick();
            if (k > 0 && k % 6 == 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (v0 !== 1'b1 || {l0, r0, l3, r3, ls, rs} !== e) begin
                    n_err++;
                    $display("FAIL b2b_k%0d: got valid=%b %0d/%0d %0d/%0d %0d/%0d, expected 1 %0d/%0d %0d/%0d %0d/%0d",
                             k, v0, l0, r0, l3, r3, ls, rs,
                             e[71:60], e[59:48], e[47:36], e[35:24], e[23:12], e[11:0]);
                end
            end else if (v0 !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL b2b_stray_valid_k%0d: got 1, expected 0", k);
            end
        end
        ce = 1'b0;
        n_vec++;
        if ({o0, o3, os} !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_overrun: got %b%b%b, expected 000", o0, o3, os);
        end
    endtask

    task automatic test_reset_midflight();
        int pulses;
        set_in(255, 255, 255, 2, 0, 0, 0);
        run_sample("pre_reset");       // leaves nonzero outputs and filter state
        ce = 1'b1; tick(); ce = 1'b0;  // edge t: MIXL
        tick(); tick();                // t+1 MIXR, t+2 FILTL
        reset = 1'b0;
        tick();                        // reset sampled while in FILTL
        n_vec++;
        if ({l0, r0, l3, r3, ls, rs} !== '0 || {v0, o0} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid: got l0=%0d l3=%0d valid=%b overrun=%b, expected 0 0 0 0", l0, l3, v0, o0);
        end
        reset = 1'b1;
        y0l = 0; y0r = 0; y3l = 0; y3r = 0; ysl = 0; ysr = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (v0 === 1'b1 || v3 === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL reset_discard: got %0d valid pulses, expected 0", pulses);
        end
        set_in(255, 255, 255, 2, 0, 0, 0);
        run_sample("post_reset");
        n_vec++;
        if (l3 !== 12'd95 || r3 !== 12'd95) begin
            n_err++;
            $display("FAIL filt_restart: got %0d/%0d, expected 95/95", l3, r3);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mono_full();
        test_stereo_maps();
        test_saturate();
        test_filter_converge();
        test_overrun();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
